// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel 3x3 line buffer: raster pixel intake, window tagging, frame framing.
// Define SOBEL_CTRL_FLUSH_EN to append a flush row so the final image row also yields windows.
module sobel_frame_ctrl #(
    parameter int          WIDTH     = 128,
    parameter int          HEIGHT    = 128,
    parameter logic [7:0]  FLUSH_VAL = 8'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    input  logic       m_ready,
    output logic       lb_enable,
    output logic [7:0] lb_pixel,
    output logic [7:0] lb_row,
    output logic [6:0] lb_col,
    output logic       wnd_valid,
    output logic [7:0] wnd_row,
    output logic [6:0] wnd_col,
    output logic       frame_start,
    output logic       frame_done,
    output logic       busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [6:0] COL_LAST  = 7'(WIDTH - 1);
    localparam logic [7:0] ROW_LAST  = 8'(HEIGHT - 1);
    localparam logic [7:0] ROW_FLUSH = 8'(HEIGHT);

    logic [1:0] state_q, state_d;
    logic [7:0] row_q, row_d;
    logic [6:0] col_q, col_d;
    logic       wnd_valid_q, wnd_valid_d;
    logic [7:0] wnd_row_q, wnd_row_d;
    logic [6:0] wnd_col_q, wnd_col_d;
    logic       frame_start_q, frame_start_d;

    logic in_run, in_flush, ready_int, accept, adv;

    always_comb begin
        in_run    = (state_q == S_RUN);
        in_flush  = (state_q == S_FLUSH);
        ready_int = in_run & m_ready & ~abort;
        accept    = ready_int & s_valid;
        // Flush row advances on downstream readiness alone; no input pixel is consumed.
        adv       = accept | (in_flush & m_ready & ~abort);
    end

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        frame_start_d = accept & (row_q == 8'd0) & (col_q == 7'd0);
        // Row 0 has no centre line loaded yet, so its advances never form a window.
        wnd_valid_d   = adv & (row_q != 8'd0);
        wnd_row_d     = adv ? (row_q - 8'd1) : wnd_row_q;
        wnd_col_d     = adv ? col_q : wnd_col_q;

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            row_d   = 8'd0;
            col_d   = 7'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_d = S_RUN;
                        row_d   = 8'd0;
                        col_d   = 7'd0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (col_q == COL_LAST) begin
                            col_d = 7'd0;
                            if (row_q == ROW_LAST) begin
`ifdef SOBEL_CTRL_FLUSH_EN
                                row_d   = ROW_FLUSH;
                                state_d = S_FLUSH;
`else
                                row_d   = 8'd0;
                                state_d = S_DONE;
`endif
                            end else begin
                                row_d = row_q + 8'd1;
                            end
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (adv) begin
                        if (col_q == COL_LAST) begin
                            col_d   = 7'd0;
                            row_d   = 8'd0;
                            state_d = S_DONE;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            row_q         <= 8'd0;
            col_q         <= 7'd0;
            wnd_valid_q   <= 1'b0;
            wnd_row_q     <= 8'd0;
            wnd_col_q     <= 7'd0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            wnd_valid_q   <= wnd_valid_d;
            wnd_row_q     <= wnd_row_d;
            wnd_col_q     <= wnd_col_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        s_ready     = ready_int;
        lb_enable   = adv;
        lb_pixel    = in_run ? s_data : (in_flush ? FLUSH_VAL : 8'd0);
        lb_row      = row_q;
        lb_col      = col_q;
        // Abort kills a pending window in the same cycle it arrives.
        wnd_valid   = wnd_valid_q & ~abort;
        wnd_row     = wnd_row_q;
        wnd_col     = wnd_col_q;
        frame_start = frame_start_q;
        frame_done  = (state_q == S_DONE) & ~abort;
        busy        = (state_q != S_IDLE);
    end

endmodule
